// File: rtl/cr_pkg.sv
// Shared definitions for the call/return sequencer and its neighbours
// (call stack, PC unit).
//   - PC_W / FLAGS_W / DEPTH / INT_VEC : default widths, stack depth, interrupt vector
//   - OP_CALL / OP_RET / OP_RETI       : op_code encodings (3 is reserved)
//   - state_t                          : sequencer FSM encoding
package cr_pkg;

   localparam int PC_W    = 9;
   localparam int FLAGS_W = 4;
   localparam int DEPTH   = 5;
   localparam logic [PC_W-1:0] INT_VEC = 9'h1F0;

   localparam logic [1:0] OP_CALL = 2'd0;
   localparam logic [1:0] OP_RET  = 2'd1;
   localparam logic [1:0] OP_RETI = 2'd2;

   typedef enum logic [2:0] {
      DRAIN   = 3'd0,
      IDLE    = 3'd1,
      PUSH    = 3'd2,
      JUMP    = 3'd3,
      READ    = 3'd4,
      POP     = 3'd5,
      RESTORE = 3'd6,
      FAULT   = 3'd7
   } state_t;

endpackage

// File: rtl/call_return_ctrl_if.sv
// Bundle between the control unit, the call/return sequencer and the call stack.
//   master : control unit / stack side (drives requests, stack read data)
//   slave  : call_return_ctrl (drives pulses, PC/flag loads, stack controls)
//
// Handshake: op_valid is a request that is only sampled while busy=0 (IDLE);
// busy acts as the inverted ready, so a request is accepted on the rising edge
// where op_valid=1 and busy=0. The requester must drop op_valid after that
// edge. Completion is signalled by a single-cycle done (with fault on
// overflow/underflow). irq_req is a level; irq_ack pulses in its accept cycle.
interface call_return_ctrl_if #(
   parameter int PC_W    = cr_pkg::PC_W,
   parameter int FLAGS_W = cr_pkg::FLAGS_W
);
   logic               op_valid;
   logic [1:0]         op_code;
   logic [PC_W-1:0]    target_pc;
   logic [PC_W-1:0]    cur_pc;
   logic [FLAGS_W-1:0] cur_flags;
   logic               irq_req;
   logic               irq_ack;
   logic               busy;
   logic               done;
   logic               fault;
   logic               pc_load;
   logic [PC_W-1:0]    pc_out;
   logic               flags_load;
   logic [FLAGS_W-1:0] flags_out;
   logic               int_en;
   logic               stk_push_en;
   logic               stk_pop_en;
   logic [PC_W-1:0]    stk_in_pc;
   logic [FLAGS_W-1:0] stk_in_flags;
   logic [PC_W-1:0]    stk_out_pc;
   logic [FLAGS_W-1:0] stk_out_flags;

   modport master (
      output op_valid, op_code, target_pc, cur_pc, cur_flags, irq_req,
             stk_out_pc, stk_out_flags,
      input  irq_ack, busy, done, fault, pc_load, pc_out, flags_load, flags_out,
             int_en, stk_push_en, stk_pop_en, stk_in_pc, stk_in_flags
   );

   modport slave (
      input  op_valid, op_code, target_pc, cur_pc, cur_flags, irq_req,
             stk_out_pc, stk_out_flags,
      output irq_ack, busy, done, fault, pc_load, pc_out, flags_load, flags_out,
             int_en, stk_push_en, stk_pop_en, stk_in_pc, stk_in_flags
   );

endinterface

// File: rtl/call_return_ctrl.sv
// Call/return sequencer for the PC/flags call stack. Turns CALL, RET, RETI and
// interrupt entry into timed push/pop, stack-read and PC/flag-load pulses,
// tracks stack depth to flag overflow/underflow, and drains the stack after
// reset (the stack's index register has no reset of its own).
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : call_return_ctrl_if.slave (requests, pulses, stack controls)
//   dbg_state : current FSM state, for observation only
module call_return_ctrl
   import cr_pkg::*;
#(
   parameter int              PC_W    = cr_pkg::PC_W,
   parameter int              FLAGS_W = cr_pkg::FLAGS_W,
   parameter int              DEPTH   = cr_pkg::DEPTH,
   parameter logic [PC_W-1:0] INT_VEC = cr_pkg::INT_VEC
) (
   input  logic                      clk,
   input  logic                      rst,
   call_return_ctrl_if.slave         bus,
   output state_t                    dbg_state
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DEPTH - 1);

   state_t             state_q, state_d;
   logic [DW-1:0]      depth_q;
   logic [DW-1:0]      drain_cnt_q;
   logic               int_en_q;
   logic               is_irq_q;
   logic               is_reti_q;
   logic [PC_W-1:0]    pc_q;
   logic [FLAGS_W-1:0] flags_q;
   logic [PC_W-1:0]    stk_pc_q;
   logic [FLAGS_W-1:0] stk_flags_q;

   logic full, empty, take_irq, call_ok;

   assign full     = (depth_q == DEPTH_MAX);
   assign empty    = (depth_q == '0);
   // An op always wins; a full stack leaves the interrupt pending.
   assign take_irq = !bus.op_valid && bus.irq_req && int_en_q && !full;
   assign call_ok  = bus.op_valid && (bus.op_code == OP_CALL) && !full;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= DRAIN;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = IDLE;
         IDLE: begin
            if (bus.op_valid) begin
               case (bus.op_code)
                  OP_CALL:          state_d = full  ? FAULT : PUSH;
                  OP_RET, OP_RETI:  state_d = empty ? FAULT : READ;
                  default:          state_d = IDLE;
               endcase
            end else if (take_irq) begin
               state_d = PUSH;
            end
         end
         PUSH:    state_d = JUMP;
         JUMP:    state_d = IDLE;
         READ:    state_d = POP;
         POP:     state_d = RESTORE;
         RESTORE: state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: depth, drain count, interrupt enable, latched values
   always_ff @(posedge clk) begin
      if (rst) begin
         depth_q     <= '0;
         drain_cnt_q <= '0;
         int_en_q    <= 1'b0;
         is_irq_q    <= 1'b0;
         is_reti_q   <= 1'b0;
         pc_q        <= '0;
         flags_q     <= '0;
         stk_pc_q    <= '0;
         stk_flags_q <= '0;
      end else begin
         case (state_q)
            DRAIN: drain_cnt_q <= drain_cnt_q + 1'b1;
            IDLE: begin
               if (call_ok) begin
                  stk_pc_q    <= bus.cur_pc + 1'b1;   // return address, wraps mod 2^PC_W
                  stk_flags_q <= bus.cur_flags;
                  pc_q        <= bus.target_pc;
                  is_irq_q    <= 1'b0;
               end else if (bus.op_valid) begin
                  is_reti_q   <= (bus.op_code == OP_RETI);
               end else if (take_irq) begin
                  stk_pc_q    <= bus.cur_pc;          // interrupted instruction re-executes
                  stk_flags_q <= bus.cur_flags;
                  pc_q        <= INT_VEC;
                  is_irq_q    <= 1'b1;
               end
            end
            PUSH:    depth_q <= depth_q + 1'b1;
            JUMP:    if (is_irq_q) int_en_q <= 1'b0;
            READ: begin
               pc_q    <= bus.stk_out_pc;
               flags_q <= bus.stk_out_flags;
            end
            POP:     depth_q <= depth_q - 1'b1;
            RESTORE: if (is_reti_q) int_en_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      bus.busy         = (state_q != IDLE);
      bus.irq_ack      = (state_q == IDLE) && take_irq;
      bus.stk_push_en  = (state_q == PUSH);
      bus.stk_pop_en   = (state_q == DRAIN) || (state_q == POP);
      bus.pc_load      = (state_q == JUMP) || (state_q == RESTORE);
      bus.done         = (state_q == JUMP) || (state_q == RESTORE) || (state_q == FAULT);
      bus.fault        = (state_q == FAULT);
      bus.flags_load   = (state_q == RESTORE) && is_reti_q;
      bus.pc_out       = pc_q;
      bus.flags_out    = flags_q;
      bus.int_en       = int_en_q;
      bus.stk_in_pc    = stk_pc_q;
      bus.stk_in_flags = stk_flags_q;
      dbg_state        = state_q;
   end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural call stack beside it.
module tb_call_return_ctrl;
   import cr_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   call_return_ctrl_if #(.PC_W(9), .FLAGS_W(4)) ifc ();
   state_t dbg_state;

   call_return_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- behavioural stack (index has no reset) ----------------
   logic [12:0] mem [0:7];
   int stk_idx = 3;   // arbitrary power-up index; the drain must clear it
   always @(posedge clk) begin
      if (ifc.stk_push_en) begin
         if (stk_idx < 8) begin
            mem[stk_idx] <= {ifc.stk_in_flags, ifc.stk_in_pc};
            stk_idx <= stk_idx + 1;
         end
      end else if (ifc.stk_pop_en && stk_idx > 0) begin
         stk_idx <= stk_idx - 1;
      end
   end
   always_comb begin
      ifc.stk_out_pc    = '0;
      ifc.stk_out_flags = '0;
      if (stk_idx > 0) begin
         ifc.stk_out_pc    = mem[stk_idx-1][8:0];
         ifc.stk_out_flags = mem[stk_idx-1][12:9];
      end
   end

   // ---------------- scoreboard ----------------
   logic [12:0] exp_q[$];   // {flags, return pc} expected on the stack
   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;

   always @(negedge clk) if (ifc.stk_push_en && ifc.stk_pop_en) overlap++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      int pops = 0, busies = 0, g = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      check("rst_state",  32'(dbg_state), 32'(DRAIN));
      check("rst_pc_out", 32'(ifc.pc_out), 32'h0);
      check("rst_stk_in", 32'(ifc.stk_in_pc), 32'h0);
      check("rst_pulses", 32'({ifc.done, ifc.fault, ifc.pc_load, ifc.stk_push_en}), 32'h0);
      while (ifc.busy && g < 20) begin
         pops   += int'(ifc.stk_pop_en);
         busies += 1;
         g++;
         @(negedge clk);
      end
      check("drain_pops", 32'(pops), 32'd5);
      check("drain_busy", 32'(busies), 32'd5);
      check("post_rst_idle", 32'(dbg_state), 32'(IDLE));
      check("post_rst_int_en", 32'(ifc.int_en), 32'h0);
   endtask

   task automatic issue(input logic [1:0] code, input logic [8:0] pc,
                        input logic [3:0] fl, input logic [8:0] tgt);
      int g = 0;
      while (ifc.busy && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) check("idle_timeout", 32'h1, 32'h0);
      ifc.op_valid  = 1'b1;
      ifc.op_code   = code;
      ifc.cur_pc    = pc;
      ifc.cur_flags = fl;
      ifc.target_pc = tgt;
      @(negedge clk);
      ifc.op_valid  = 1'b0;
   endtask

   task automatic do_call(input logic [8:0] pc, input logic [3:0] fl,
                          input logic [8:0] tgt, input bit exp_fault);
      logic [8:0] ret_pc;
      ret_pc = pc + 9'd1;
      issue(OP_CALL, pc, fl, tgt);
      if (exp_fault) begin
         check("call_ovf_done",  32'(ifc.done), 32'h1);
         check("call_ovf_fault", 32'(ifc.fault), 32'h1);
         check("call_ovf_push",  32'({ifc.stk_push_en, ifc.pc_load}), 32'h0);
         @(negedge clk);
         check("call_ovf_idle",  32'(ifc.busy), 32'h0);
      end else begin
         check("call_push",      32'(ifc.stk_push_en), 32'h1);
         check("call_in_pc",     32'(ifc.stk_in_pc), 32'(ret_pc));
         check("call_in_flags",  32'(ifc.stk_in_flags), 32'(fl));
         check("call_early_done",32'(ifc.done), 32'h0);
         exp_q.push_back({fl, ret_pc});
         @(negedge clk);
         check("call_jump", 32'({ifc.pc_load, ifc.done, ifc.fault, ifc.stk_push_en}), 32'b1100);
         check("call_pc_out", 32'(ifc.pc_out), 32'(tgt));
         @(negedge clk);
      end
   endtask

   task automatic do_ret(input bit reti, input bit exp_fault);
      logic [12:0] e;
      issue(reti ? OP_RETI : OP_RET, 9'h0, 4'h0, 9'h0);
      if (exp_fault) begin
         check("ret_unf_done",  32'({ifc.done, ifc.fault}), 32'b11);
         check("ret_unf_quiet", 32'({ifc.stk_pop_en, ifc.pc_load}), 32'h0);
         @(negedge clk);
         check("ret_unf_after", 32'({ifc.stk_pop_en, ifc.pc_load, ifc.busy}), 32'h0);
      end else begin
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'h1, 32'h0);
            e = '0;
         end else begin
            e = exp_q.pop_back();
         end
         check("ret_read", 32'({ifc.stk_pop_en, ifc.done, ifc.pc_load}), 32'h0);
         @(negedge clk);
         check("ret_pop",  32'({ifc.stk_pop_en, ifc.done}), 32'b10);
         @(negedge clk);
         check("ret_restore", 32'({ifc.pc_load, ifc.done, ifc.fault, ifc.stk_pop_en}), 32'b1100);
         check("ret_pc_out",  32'(ifc.pc_out), 32'(e[8:0]));
         check("ret_flags_load", 32'(ifc.flags_load), 32'(reti));
         if (reti) check("reti_flags_out", 32'(ifc.flags_out), 32'(e[12:9]));
         @(negedge clk);
         if (reti) check("reti_int_en", 32'(ifc.int_en), 32'h1);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      ifc.op_valid = 1'b0; ifc.op_code = 2'd0; ifc.target_pc = '0;
      ifc.cur_pc = '0; ifc.cur_flags = '0; ifc.irq_req = 1'b0;

      do_reset();

      // RET with an empty stack
      do_ret(1'b0, 1'b1);

      // CALL 0x010 -> 0x080, then RET to 0x011
      do_call(9'h010, 4'h3, 9'h080, 1'b0);
      do_ret(1'b0, 1'b0);

      // Fill to 5, 6th CALL overflows, unwind 5 then underflow
      for (int i = 0; i < 5; i++)
         do_call(9'(i * 32 + 3), 4'(i), 9'(9'h100 + i), 1'b0);
      do_call(9'h0AA, 4'hF, 9'h0BB, 1'b1);
      for (int i = 0; i < 5; i++) do_ret(1'b0, 1'b0);
      do_ret(1'b0, 1'b1);

      // Reserved op: consumed in one cycle, nothing happens
      issue(2'd3, 9'h055, 4'h5, 9'h066);
      check("rsvd_quiet", 32'({ifc.busy, ifc.done, ifc.stk_push_en, ifc.pc_load}), 32'h0);

      // CALL + RETI to enable interrupts
      do_call(9'h050, 4'h6, 9'h100, 1'b0);
      do_ret(1'b1, 1'b0);

      // Interrupt entry at cur_pc=0x1FF, flags A
      ifc.cur_pc = 9'h1FF; ifc.cur_flags = 4'hA; ifc.irq_req = 1'b1;
      #1;
      check("irq_ack", 32'(ifc.irq_ack), 32'h1);
      @(negedge clk);
      ifc.irq_req = 1'b0;
      check("irq_push",  32'({ifc.stk_push_en, ifc.irq_ack}), 32'b10);
      check("irq_in_pc", 32'(ifc.stk_in_pc), 32'h1FF);
      check("irq_in_fl", 32'(ifc.stk_in_flags), 32'hA);
      exp_q.push_back({4'hA, 9'h1FF});
      @(negedge clk);
      check("irq_jump",   32'({ifc.pc_load, ifc.done}), 32'b11);
      check("irq_vector", 32'(ifc.pc_out), 32'h1F0);
      @(negedge clk);
      check("irq_int_en_clr", 32'(ifc.int_en), 32'h0);
      do_ret(1'b1, 1'b0);

      // Wrap of cur_pc+1 on CALL
      do_call(9'h1FF, 4'h1, 9'h020, 1'b0);
      do_ret(1'b0, 1'b0);

      // Full stack: pending interrupt is not taken
      for (int i = 0; i < 5; i++) do_call(9'(9'h040 + i), 4'h2, 9'h070, 1'b0);
      ifc.irq_req = 1'b1;
      #1;
      check("irq_full_no_ack", 32'(ifc.irq_ack), 32'h0);
      @(negedge clk);
      check("irq_full_idle", 32'({ifc.busy, ifc.stk_push_en}), 32'h0);
      ifc.irq_req = 1'b0;

      // Reset mid-run empties the stack again
      do_reset();
      do_ret(1'b0, 1'b1);

      check("no_push_pop_overlap", 32'(overlap), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
